// File: rtl/systolic_mac_pe.sv
// Output-stationary systolic MAC processing element: registered operand forwarding,
// a two-stage multiply/saturating-accumulate datapath, and a drain shift chain.
module systolic_mac_pe #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 24,
  parameter int SIGNED = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              en,
  input  logic [DATA_W-1:0] a_in,
  input  logic [DATA_W-1:0] b_in,
  input  logic              in_valid,
  input  logic              first_in,
  output logic [DATA_W-1:0] a_out,
  output logic [DATA_W-1:0] b_out,
  output logic              out_valid,
  output logic              first_out,
  input  logic              drain,
  input  logic [ACC_W-1:0]  psum_in,
  input  logic              ovf_in,
  output logic [ACC_W-1:0]  psum_out,
  output logic              ovf_out
);

  localparam int   PW  = 2 * DATA_W;
  localparam logic SGN = (SIGNED != 0);

  logic [PW-1:0]    a_ext, b_ext, prod_full;
  logic [PW-1:0]    prod_r;
  logic             prod_v, prod_first;
  logic [ACC_W-1:0] acc;
  logic             ovf;

  logic [ACC_W:0]   prod_ext, acc_ext, sum;
  logic             sum_ovf;
  logic [ACC_W-1:0] sat_val, prod_acc;

  // Extending both operands to the full product width makes a plain multiply
  // correct for either signedness once truncated to PW bits.
  always_comb begin
    a_ext = {PW{SGN & a_in[DATA_W-1]}};
    a_ext[DATA_W-1:0] = a_in;
    b_ext = {PW{SGN & b_in[DATA_W-1]}};
    b_ext[DATA_W-1:0] = b_in;
    prod_full = a_ext * b_ext;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_out      <= '0;
      b_out      <= '0;
      out_valid  <= 1'b0;
      first_out  <= 1'b0;
      prod_r     <= '0;
      prod_v     <= 1'b0;
      prod_first <= 1'b0;
    end else if (en) begin
      a_out      <= a_in;
      b_out      <= b_in;
      out_valid  <= in_valid;
      first_out  <= in_valid & first_in;
      prod_r     <= prod_full;
      prod_v     <= in_valid;
      prod_first <= in_valid & first_in;
    end
  end

  // One guard bit above the accumulator detects overflow in both modes.
  always_comb begin
    prod_ext = {(ACC_W+1){SGN & prod_r[PW-1]}};
    prod_ext[PW-1:0] = prod_r;
    acc_ext  = {SGN & acc[ACC_W-1], acc};
    sum      = acc_ext + prod_ext;
    prod_acc = prod_ext[ACC_W-1:0];
    if (SGN) begin
      sum_ovf = sum[ACC_W] ^ sum[ACC_W-1];
      sat_val = sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end else begin
      sum_ovf = sum[ACC_W];
      sat_val = {ACC_W{1'b1}};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc <= '0;
      ovf <= 1'b0;
    end else if (en) begin
      if (drain) begin
        acc <= psum_in;
        ovf <= ovf_in;
      end else if (prod_v && prod_first) begin
        acc <= prod_acc;
        ovf <= 1'b0;
      end else if (prod_v) begin
        if (sum_ovf) begin
          acc <= sat_val;
          ovf <= 1'b1;
        end else begin
          acc <= sum[ACC_W-1:0];
        end
      end
    end
  end

  assign psum_out = acc;
  assign ovf_out  = ovf;

endmodule
